// File: rtl/nec_frame_decoder_pkg.sv
// Shared constants for the NEC frame decoder: pulse-width windows in ticks,
// FSM state codes and the received-frame layout.
package nec_frame_decoder_pkg;

    localparam logic [10:0] WIDTH_MAX      = 11'd2047;

    localparam logic [10:0] LEAD_MARK_MIN  = 11'd675;
    localparam logic [10:0] LEAD_MARK_MAX  = 11'd1125;
    localparam logic [10:0] LEAD_SPACE_MIN = 11'd338;
    localparam logic [10:0] LEAD_SPACE_MAX = 11'd562;
    localparam logic [10:0] REP_SPACE_MIN  = 11'd169;
    localparam logic [10:0] REP_SPACE_MAX  = 11'd281;
    localparam logic [10:0] BIT_MIN        = 11'd42;
    localparam logic [10:0] BIT_MAX        = 11'd70;
    localparam logic [10:0] ONE_MIN        = 11'd127;
    localparam logic [10:0] ONE_MAX        = 11'd211;

    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_LEAD_MARK  = 3'd1;
    localparam logic [2:0] ST_LEAD_SPACE = 3'd2;
    localparam logic [2:0] ST_BIT_MARK   = 3'd3;
    localparam logic [2:0] ST_BIT_SPACE  = 3'd4;
    localparam logic [2:0] ST_STOP_MARK  = 3'd5;
    localparam logic [2:0] ST_REP_MARK   = 3'd6;
    localparam logic [2:0] ST_CHECK      = 3'd7;

    // Bits arrive LSB-first, so the first byte on air lands in [7:0].
    typedef struct packed {
        logic [7:0] cmd_n;
        logic [7:0] cmd;
        logic [7:0] addr_n;
        logic [7:0] addr;
    } nec_frame_t;

    function automatic logic in_window(input logic [10:0] w, input logic [10:0] lo,
                                       input logic [10:0] hi);
        return (w >= lo) && (w <= hi);
    endfunction

endpackage

// File: rtl/nec_frame_decoder_if.sv
// Byte stream handshake between the decoder and the downstream forwarding stage.
interface nec_frame_decoder_if;
    logic [7:0] o_byte;
    logic       o_byte_valid;
    logic       i_byte_ready;

    modport master (output o_byte, output o_byte_valid, input i_byte_ready);
    modport slave  (input o_byte, input o_byte_valid, output i_byte_ready);
endinterface

// File: rtl/nec_frame_decoder_ir_input_conditioner.sv
// Synchronises the raw IR line, normalises it to mark=1, detects edges and
// produces the free-running measurement tick.
module nec_frame_decoder_ir_input_conditioner #(
    parameter int TICK_DIV      = 500,
    parameter bit IR_ACTIVE_LOW = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic ir_in,
    output logic mark,
    output logic rise,
    output logic fall,
    output logic tick
);
    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(TICK_DIV - 1);
    // Synchroniser resets to the idle (space) level so reset release creates no edge.
    localparam logic IDLE_LEVEL = IR_ACTIVE_LOW;

    logic [1:0]       sync_reg;
    logic             mark_d_reg;
    logic [CNT_W-1:0] div_reg;
    logic             tick_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_reg   <= {2{IDLE_LEVEL}};
            mark_d_reg <= 1'b0;
        end else begin
            sync_reg   <= {sync_reg[0], ir_in};
            mark_d_reg <= mark;
        end
    end

    assign mark = IR_ACTIVE_LOW ? ~sync_reg[1] : sync_reg[1];
    assign rise = mark & ~mark_d_reg;
    assign fall = ~mark & mark_d_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_reg  <= '0;
            tick_reg <= 1'b0;
        end else if (div_reg == DIV_LAST) begin
            div_reg  <= '0;
            tick_reg <= 1'b1;
        end else begin
            div_reg  <= div_reg + CNT_W'(1);
            tick_reg <= 1'b0;
        end
    end

    assign tick = tick_reg;

endmodule

// File: rtl/nec_frame_decoder.sv
// NEC IR frame decoder: measures mark/space widths, assembles the 32-bit frame,
// validates the inverse bytes and streams address then command downstream.
module nec_frame_decoder
    import nec_frame_decoder_pkg::*;
#(
    parameter int CLK_HZ         = 50_000_000,
    parameter int TICK_HZ        = 100_000,
    parameter bit IR_ACTIVE_LOW  = 1'b1,
    parameter bit CHECK_ADDR_INV = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      ir_in,
    nec_frame_decoder_if.master       stream,
    output logic [15:0]               o_addr,
    output logic [7:0]                o_cmd,
    output logic                      o_frame_valid,
    output logic                      o_repeat,
    output logic                      o_err,
    output logic                      o_overrun
);
    localparam int TICK_DIV = (CLK_HZ / TICK_HZ > 0) ? CLK_HZ / TICK_HZ : 1;

    logic        mark, rise, fall, tick, edge_any;
    logic [10:0] width_reg;
    logic [2:0]  state_reg;
    logic [4:0]  bit_cnt_reg;
    logic [31:0] shift_reg;
    logic        have_frame_reg;
    nec_frame_t  rx;
    logic        bit_width_ok, one_width_ok, frame_ok, check_pass, timeout;
    logic        handshake, stream_free, stream_sel_reg;
    logic [7:0]  cmd_hold_reg;

    nec_frame_decoder_ir_input_conditioner #(
        .TICK_DIV      (TICK_DIV),
        .IR_ACTIVE_LOW (IR_ACTIVE_LOW)
    ) u_cond (
        .clk   (clk),
        .rst   (rst),
        .ir_in (ir_in),
        .mark  (mark),
        .rise  (rise),
        .fall  (fall),
        .tick  (tick)
    );

    assign edge_any = rise | fall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            width_reg <= '0;
        else if (edge_any)
            width_reg <= '0;
        else if (tick && (width_reg != WIDTH_MAX))
            width_reg <= width_reg + 11'd1;
    end

    assign rx           = shift_reg;
    assign bit_width_ok = in_window(width_reg, BIT_MIN, BIT_MAX);
    assign one_width_ok = in_window(width_reg, ONE_MIN, ONE_MAX);
    assign frame_ok     = ((rx.cmd ^ rx.cmd_n) == 8'hFF) &&
                          (!CHECK_ADDR_INV || ((rx.addr ^ rx.addr_n) == 8'hFF));
    assign check_pass   = (state_reg == ST_CHECK) && frame_ok;
    // A line stuck without edges only matters once a frame is under way.
    assign timeout      = (state_reg != ST_IDLE) && (state_reg != ST_CHECK) &&
                          !edge_any && (width_reg == WIDTH_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            bit_cnt_reg    <= '0;
            shift_reg      <= '0;
            have_frame_reg <= 1'b0;
            o_addr         <= '0;
            o_cmd          <= '0;
            o_frame_valid  <= 1'b0;
            o_repeat       <= 1'b0;
            o_err          <= 1'b0;
        end else begin
            o_frame_valid <= 1'b0;
            o_repeat      <= 1'b0;
            o_err         <= 1'b0;
            case (state_reg)
                ST_IDLE: if (edge_any && mark) state_reg <= ST_LEAD_MARK;
                ST_LEAD_MARK: if (fall) begin
                    if (in_window(width_reg, LEAD_MARK_MIN, LEAD_MARK_MAX)) state_reg <= ST_LEAD_SPACE;
                    else begin state_reg <= ST_IDLE; o_err <= 1'b1; end
                end
                ST_LEAD_SPACE: if (rise) begin
                    bit_cnt_reg <= '0;
                    if (in_window(width_reg, LEAD_SPACE_MIN, LEAD_SPACE_MAX)) state_reg <= ST_BIT_MARK;
                    else if (in_window(width_reg, REP_SPACE_MIN, REP_SPACE_MAX)) state_reg <= ST_REP_MARK;
                    else begin state_reg <= ST_IDLE; o_err <= 1'b1; end
                end
                ST_BIT_MARK: if (fall) begin
                    if (bit_width_ok) state_reg <= ST_BIT_SPACE;
                    else begin state_reg <= ST_IDLE; o_err <= 1'b1; end
                end
                ST_BIT_SPACE: if (rise) begin
                    if (bit_width_ok || one_width_ok) begin
                        shift_reg   <= {one_width_ok, shift_reg[31:1]};
                        bit_cnt_reg <= bit_cnt_reg + 5'd1;
                        state_reg   <= (bit_cnt_reg == 5'd31) ? ST_STOP_MARK : ST_BIT_MARK;
                    end else begin
                        state_reg <= ST_IDLE;
                        o_err     <= 1'b1;
                    end
                end
                ST_STOP_MARK: if (fall) begin
                    if (bit_width_ok) state_reg <= ST_CHECK;
                    else begin state_reg <= ST_IDLE; o_err <= 1'b1; end
                end
                ST_REP_MARK: if (fall) begin
                    state_reg <= ST_IDLE;
                    if (bit_width_ok) o_repeat <= have_frame_reg;
                    else o_err <= 1'b1;
                end
                ST_CHECK: begin
                    state_reg <= ST_IDLE;
                    if (frame_ok) begin
                        o_addr         <= CHECK_ADDR_INV ? {8'h00, rx.addr} : {rx.addr_n, rx.addr};
                        o_cmd          <= rx.cmd;
                        o_frame_valid  <= 1'b1;
                        have_frame_reg <= 1'b1;
                    end else begin
                        o_err <= 1'b1;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
            if (timeout) begin
                state_reg <= ST_IDLE;
                o_err     <= 1'b1;
            end
        end
    end

    // The accepting handshake is applied first so a frame checked on the same
    // cycle the command byte leaves can load straight into the freed stream.
    assign handshake   = stream.o_byte_valid & stream.i_byte_ready;
    assign stream_free = !stream.o_byte_valid || (handshake && stream_sel_reg);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stream.o_byte       <= '0;
            stream.o_byte_valid <= 1'b0;
            stream_sel_reg      <= 1'b0;
            cmd_hold_reg        <= '0;
            o_overrun           <= 1'b0;
        end else begin
            o_overrun <= 1'b0;
            if (handshake) begin
                if (!stream_sel_reg) begin
                    stream.o_byte  <= cmd_hold_reg;
                    stream_sel_reg <= 1'b1;
                end else begin
                    stream.o_byte_valid <= 1'b0;
                    stream_sel_reg      <= 1'b0;
                end
            end
            if (check_pass) begin
                if (stream_free) begin
                    stream.o_byte       <= rx.addr;
                    stream.o_byte_valid <= 1'b1;
                    stream_sel_reg      <= 1'b0;
                    cmd_hold_reg        <= rx.cmd;
                end else begin
                    o_overrun <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_nec_frame_decoder.sv
// Scoreboard bench for nec_frame_decoder: randomly jittered NEC frames, repeats
// and fault cases; expected events and stream bytes come from a frame-level model.
module tb_nec_frame_decoder;
    localparam int CLK_HZ  = 100_000;   // one tick per clock keeps frames short in simulation
    localparam int TICK_HZ = 100_000;

    localparam int K_FRAME = 1;
    localparam int K_OVR   = 2;
    localparam int K_REP   = 3;
    localparam int K_ERR   = 4;

    typedef struct {
        int          kind;
        logic [15:0] addr;
        logic [7:0]  cmd;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ir_in = 1'b1;
    logic [15:0] o_addr;
    logic [7:0]  o_cmd;
    logic        o_frame_valid, o_repeat, o_err, o_overrun;

    nec_frame_decoder_if sif ();

    nec_frame_decoder #(
        .CLK_HZ         (CLK_HZ),
        .TICK_HZ        (TICK_HZ),
        .IR_ACTIVE_LOW  (1'b1),
        .CHECK_ADDR_INV (1'b1)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .ir_in         (ir_in),
        .stream        (sif),
        .o_addr        (o_addr),
        .o_cmd         (o_cmd),
        .o_frame_valid (o_frame_valid),
        .o_repeat      (o_repeat),
        .o_err         (o_err),
        .o_overrun     (o_overrun)
    );

    always #5 clk = ~clk;

    int          cyc = 0;
    int          last_stop_cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    ev_t         ev_q[$];
    logic [7:0]  byte_q[$];
    logic [15:0] last_addr = '0;
    logic [7:0]  last_cmd = '0;
    bit          have_frame = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic pop_expect(input int kind);
        ev_t e;
        if (ev_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL event_unexpected: got event kind %0d, required none", kind);
            return;
        end
        e = ev_q.pop_front();
        check("event_kind", kind, e.kind);
        if (kind == K_FRAME) begin
            check("o_addr", {16'h0, o_addr}, {16'h0, e.addr});
            check("o_cmd", {24'h0, o_cmd}, {24'h0, e.cmd});
            check("frame_latency", cyc - last_stop_cyc, 4);
        end
    endtask

    // Monitor: every pulse and every accepted stream byte is matched against the queues.
    always @(negedge clk) begin
        if (!rst) begin
            if (o_frame_valid) pop_expect(K_FRAME);
            if (o_overrun)     pop_expect(K_OVR);
            if (o_repeat)      pop_expect(K_REP);
            if (o_err)         pop_expect(K_ERR);
            if (sif.o_byte_valid && sif.i_byte_ready) begin
                if (byte_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL stream_unexpected: got byte %0h, required none", sif.o_byte);
                end else begin
                    check("stream_byte", {24'h0, sif.o_byte}, {24'h0, byte_q.pop_front()});
                end
            end
        end
    end

    function automatic int jit(input int nom);
        return nom - nom / 10 + int'($urandom_range(0, nom / 5));
    endfunction

    task automatic drive(input bit m, input int n);
        ir_in = m ? 1'b0 : 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // Frame-level model: inverse checks decide frame vs error; a frame finding
    // stream bytes still owed downstream is latched but reported as overrun.
    task automatic expect_frame(input logic [7:0] a, input logic [7:0] an,
                                input logic [7:0] c, input logic [7:0] cn);
        ev_t e;
        e.addr = {8'h00, a};
        e.cmd  = c;
        if (((a ^ an) == 8'hFF) && ((c ^ cn) == 8'hFF)) begin
            e.kind = K_FRAME;
            ev_q.push_back(e);
            if (byte_q.size() == 0) begin
                byte_q.push_back(a);
                byte_q.push_back(c);
            end else begin
                e.kind = K_OVR;
                ev_q.push_back(e);
            end
            last_addr  = {8'h00, a};
            last_cmd   = c;
            have_frame = 1'b1;
        end else begin
            e.kind = K_ERR;
            ev_q.push_back(e);
        end
    endtask

    task automatic send_frame(input logic [7:0] a, input logic [7:0] an,
                              input logic [7:0] c, input logic [7:0] cn);
        logic [31:0] w;
        w = {cn, c, an, a};
        expect_frame(a, an, c, cn);
        drive(1'b1, jit(900));
        drive(1'b0, jit(450));
        for (int i = 0; i < 32; i++) begin
            drive(1'b1, jit(56));
            drive(1'b0, w[i] ? jit(169) : jit(56));
        end
        drive(1'b1, jit(56));
        last_stop_cyc = cyc;
        drive(1'b0, 200 + int'($urandom_range(0, 100)));
    endtask

    task automatic send_repeat();
        ev_t e;
        if (have_frame) begin
            e.kind = K_REP;
            e.addr = last_addr;
            e.cmd  = last_cmd;
            ev_q.push_back(e);
        end
        drive(1'b1, jit(900));
        drive(1'b0, jit(225));
        drive(1'b1, jit(56));
        drive(1'b0, 200);
    endtask

    task automatic set_ready(input logic r);
        @(posedge clk);
        #1 sif.i_byte_ready = r;
        @(negedge clk);
    endtask

    task automatic push_err();
        ev_t e;
        e.kind = K_ERR;
        e.addr = '0;
        e.cmd  = '0;
        ev_q.push_back(e);
    endtask

    initial begin
        logic [7:0] ra, rc, rcn;
        sif.i_byte_ready = 1'b1;
        rst = 1'b1;
        repeat (5) @(negedge clk);
        check("reset_o_byte", {24'h0, sif.o_byte}, 32'h0);
        check("reset_o_byte_valid", {31'h0, sif.o_byte_valid}, 32'h0);
        check("reset_o_addr", {16'h0, o_addr}, 32'h0);
        check("reset_o_cmd", {24'h0, o_cmd}, 32'h0);
        check("reset_pulses", {28'h0, o_frame_valid, o_repeat, o_err, o_overrun}, 32'h0);
        rst = 1'b0;
        repeat (20) @(negedge clk);

        send_repeat();                                   // no frame yet: silent
        send_frame(8'h00, 8'hFF, 8'h45, 8'hBA);
        send_repeat();
        check("repeat_addr_hold", {16'h0, o_addr}, {16'h0, last_addr});
        check("repeat_cmd_hold", {24'h0, o_cmd}, {24'h0, last_cmd});
        send_frame(8'h00, 8'hFF, 8'h45, 8'hBB);          // bad command inverse
        check("bad_inv_addr_hold", {16'h0, o_addr}, 32'h0000);
        check("bad_inv_cmd_hold", {24'h0, o_cmd}, 32'h45);

        set_ready(1'b0);
        send_frame(8'h10, 8'hEF, 8'h20, 8'hDF);
        send_frame(8'h55, 8'hAA, 8'h66, 8'h99);          // arrives while stream stalled
        check("stall_o_byte", {24'h0, sif.o_byte}, 32'h10);
        check("stall_valid", {31'h0, sif.o_byte_valid}, 32'h1);
        check("stall_latched_addr", {16'h0, o_addr}, 32'h0055);
        repeat (50) @(negedge clk);
        check("stall_o_byte_hold", {24'h0, sif.o_byte}, 32'h10);
        set_ready(1'b1);
        repeat (10) @(negedge clk);

        push_err();                                      // lead mark too short
        drive(1'b1, 500);
        drive(1'b0, 300);

        push_err();                                      // stuck mark mid-bit
        drive(1'b1, jit(900));
        drive(1'b0, jit(450));
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, jit(56));
            drive(1'b0, jit(56));
        end
        drive(1'b1, 2500);
        drive(1'b0, 300);

        for (int k = 0; k < 2; k++) begin
            ra  = 8'($urandom);
            rc  = 8'($urandom);
            rcn = ($urandom_range(0, 3) == 0) ? (~rc ^ 8'h04) : ~rc;
            send_frame(ra, ~ra, rc, rcn);
        end

        drive(1'b1, jit(900));                           // reset lands mid-frame
        drive(1'b0, jit(450));
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, jit(56));
            drive(1'b0, jit(169));
        end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("midrst_o_addr", {16'h0, o_addr}, 32'h0);
        check("midrst_o_cmd", {24'h0, o_cmd}, 32'h0);
        check("midrst_stream", {23'h0, sif.o_byte_valid, sif.o_byte}, 32'h0);
        check("midrst_pulses", {28'h0, o_frame_valid, o_repeat, o_err, o_overrun}, 32'h0);
        have_frame = 1'b0;
        last_addr  = '0;
        last_cmd   = '0;
        rst = 1'b0;
        repeat (20) @(negedge clk);
        ra = 8'($urandom);
        rc = 8'($urandom);
        send_frame(ra, ~ra, rc, ~rc);

        for (int i = 0; i < 2000 && (ev_q.size() != 0 || byte_q.size() != 0); i++)
            @(negedge clk);
        check("events_drained", ev_q.size(), 0);
        check("bytes_drained", byte_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
